// File: rtl/imem_arb_pkg.sv
// Shared encodings for the instruction-memory arbiter: FSM states and access owner.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/imem_arb_starve.sv
// Priority select for the arbiter: fetch wins unless debug has waited through
// STARVE_MAX consecutive fetch grants, in which case debug is forced through.
module imem_arb_starve
  import imem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic d_req,
  input  logic grant_en,
  output logic sel_d
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sel_d = d_req && (!f_req || (cnt_q == CNT_MAX));
    cnt_d = cnt_q;
    if (!d_req || (grant_en && sel_d)) begin
      cnt_d = '0;
    end else if (grant_en && f_req && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Two-requester (fetch/debug) arbiter for a combinational instruction-memory port.
// Optional alignment check enabled by defining IMEM_ARB_ALIGN_CHK_EN (adds f_err/d_err).
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_rdata
`ifdef IMEM_ARB_ALIGN_CHK_EN
  ,
  output logic              f_err,
  output logic              d_err
`endif
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef IMEM_ARB_ALIGN_CHK_EN
  logic              err_q, err_d;
`endif

  logic              grant_en;
  logic              sel_d;
  logic              any_req;
  logic [ADDR_W-1:0] gnt_addr;

  assign grant_en = !rst && (state_q != WAIT);
  assign any_req  = f_req || d_req;
  assign gnt_addr = sel_d ? d_addr : f_addr;

  imem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .f_req   (f_req),
    .d_req   (d_req),
    .grant_en(grant_en),
    .sel_d   (sel_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= OWN_F;
      m_addr_q  <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef IMEM_ARB_ALIGN_CHK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      m_addr_q  <= m_addr_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef IMEM_ARB_ALIGN_CHK_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    m_addr_d  = m_addr_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef IMEM_ARB_ALIGN_CHK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          owner_d  = sel_d ? OWN_D : OWN_F;
          cnt_d    = '0;
          state_d  = WAIT;
          m_addr_d = gnt_addr;
`ifdef IMEM_ARB_ALIGN_CHK_EN
          // Misaligned grant bypasses memory: zero data is staged now so it lands with rvalid.
          err_d = (gnt_addr[1:0] != 2'b00);
          if (err_d) begin
            state_d  = RESP;
            m_addr_d = m_addr_q;
            if (sel_d) d_rdata_d = '0;
            else       f_rdata_d = '0;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAT_LAST) begin
          state_d = RESP;
          if (owner_q == OWN_D) d_rdata_d = m_rdata;
          else                  f_rdata_d = m_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    f_gnt    = grant_en && f_req && !sel_d;
    d_gnt    = grant_en && sel_d;
    f_rvalid = !rst && (state_q == RESP) && (owner_q == OWN_F);
    d_rvalid = !rst && (state_q == RESP) && (owner_q == OWN_D);
    f_rdata  = f_rdata_q;
    d_rdata  = d_rdata_q;
    m_addr   = m_addr_q;
`ifdef IMEM_ARB_ALIGN_CHK_EN
    f_err    = f_rvalid && err_q;
    d_err    = d_rvalid && err_q;
`endif
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: random fetch/debug traffic, contention phase and
// mid-access resets, checked against a cycle-timeline reference model.
module tb_imem_arbiter;

  localparam int unsigned MEM_LAT    = 3;
  localparam int unsigned STARVE_MAX = 4;
`ifdef IMEM_ARB_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req, d_req;
  logic [31:0] f_addr, d_addr;
  logic        f_gnt, d_gnt, f_rvalid, d_rvalid;
  logic [31:0] f_rdata, d_rdata, m_addr, m_rdata;
`ifdef IMEM_ARB_ALIGN_CHK_EN
  logic        f_err, d_err;
`endif

  always #5 clk = ~clk;

  imem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_gnt   (f_gnt),
    .f_rvalid(f_rvalid),
    .f_rdata (f_rdata),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .m_addr  (m_addr),
    .m_rdata (m_rdata)
`ifdef IMEM_ARB_ALIGN_CHK_EN
    ,
    .f_err   (f_err),
    .d_err   (d_err)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  assign m_rdata = mem_word(m_addr);

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  bit          contend = 1'b0;

  logic [31:0] last_f = '0, last_d = '0, exp_maddr = '0;
  int unsigned starve = 0, next_free = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, req_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an access granted at cycle c owns the port until its response
  // cycle; the next grant is possible exactly then.
  always @(negedge clk) begin
    bit          free, want_d, mis;
    logic [31:0] a;
    exp_t        e;
    if (rst) begin
      check("gnt_in_rst", 32'({f_gnt, d_gnt}), 32'd0);
      sb_q.delete();
      starve    = 0;
      last_f    = '0;
      last_d    = '0;
      exp_maddr = '0;
      next_free = cyc + 1;
    end else begin
      check("maddr", m_addr, exp_maddr);
      free   = (cyc >= next_free);
      want_d = d_req && (!f_req || (starve == STARVE_MAX));
      check("f_gnt", 32'(f_gnt), 32'(free && f_req && !want_d));
      check("d_gnt", 32'(d_gnt), 32'(free && want_d));
      if (free && (f_req || d_req)) begin
        a      = want_d ? d_addr : f_addr;
        mis    = ALIGN && (a[1:0] != 2'b00);
        e.is_d = want_d;
        e.err  = mis;
        e.data = mis ? 32'd0 : mem_word(a);
        e.due  = cyc + (mis ? 1 : MEM_LAT + 1);
        sb_q.push_back(e);
        next_free = e.due;
        if (!mis) exp_maddr = a;
      end
      if (!d_req || (free && want_d)) starve = 0;
      else if (free && f_req && starve < STARVE_MAX) starve++;
    end
  end

  // Monitor: consumes scoreboard entries whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t m;
    if (!rst) begin
      if (f_rvalid || d_rvalid) begin
        check("rv_both", 32'(f_rvalid && d_rvalid), 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rv_unexpected cyc=%0d actual f_rvalid=%0b d_rvalid=%0b expected none", cyc, f_rvalid, d_rvalid);
        end else begin
          m = sb_q.pop_front();
          check("rv_cycle", cyc, m.due);
          check("rv_port", 32'(d_rvalid), 32'(m.is_d));
          check("rv_data", m.is_d ? d_rdata : f_rdata, m.data);
`ifdef IMEM_ARB_ALIGN_CHK_EN
          check("rv_err", 32'({f_err, d_err}), m.is_d ? 32'({1'b0, m.err}) : 32'({m.err, 1'b0}));
`endif
          if (m.is_d) last_d = m.data;
          else        last_f = m.data;
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rv_missing cyc=%0d actual none expected rvalid at cyc=%0d", cyc, sb_q[0].due);
        void'(sb_q.pop_front());
      end
      check("f_rdata_hold", f_rdata, last_f);
      check("d_rdata_hold", d_rdata, last_d);
    end
  end

  // Fetch requester: holds req/addr until granted, occasionally withdraws early.
  initial begin
    int unsigned limit, n;
    bit          got;
    f_req  = 1'b0;
    f_addr = '0;
    wait (rst == 1'b0);
    forever begin
      repeat (contend ? 0 : $urandom_range(0, 4)) begin @(posedge clk); #1; end
      f_req  = 1'b1;
      f_addr = rand_addr();
      limit  = (!contend && $urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 300;
      n = 0;
      got = 1'b0;
      while (!got && n < limit) begin
        @(negedge clk);
        if (f_gnt) got = 1'b1;
        else n++;
      end
      if (!got && limit == 300) begin
        checks++;
        errors++;
        $display("FAIL f_timeout cyc=%0d actual no f_gnt expected grant within 300 cycles", cyc);
      end
      @(posedge clk); #1;
      f_req = 1'b0;
    end
  end

  // Debug requester: same protocol as fetch, independent randomisation.
  initial begin
    int unsigned limit, n;
    bit          got;
    d_req  = 1'b0;
    d_addr = '0;
    wait (rst == 1'b0);
    forever begin
      repeat (contend ? 0 : $urandom_range(0, 6)) begin @(posedge clk); #1; end
      d_req  = 1'b1;
      d_addr = rand_addr();
      limit  = (!contend && $urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 300;
      n = 0;
      got = 1'b0;
      while (!got && n < limit) begin
        @(negedge clk);
        if (d_gnt) got = 1'b1;
        else n++;
      end
      if (!got && limit == 300) begin
        checks++;
        errors++;
        $display("FAIL d_timeout cyc=%0d actual no d_gnt expected grant within 300 cycles", cyc);
      end
      @(posedge clk); #1;
      d_req = 1'b0;
    end
  end

  initial begin
    int unsigned n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (1200) @(posedge clk);
    contend = 1'b1;
    repeat (500) @(posedge clk);
    contend = 1'b0;
    // Reset one cycle after a grant, while the access is still waiting on memory.
    for (int k = 0; k < 6; k++) begin
      n = 0;
      @(negedge clk);
      while (!(f_gnt || d_gnt) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n == 100) begin
        checks++;
        errors++;
        $display("FAIL rst_grant_wait cyc=%0d actual no grant expected one within 100 cycles", cyc);
      end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat ($urandom_range(10, 40)) @(posedge clk);
    end
    repeat (1000) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single combinational instruction-memory read port between two requesters: core fetch (F) and debug/program-inspection reader (D).
- Sits between the fetch stage / debug module and the instruction memory.
- Holds the memory address stable for a configurable number of wait cycles, then returns registered read data.
- F has priority; D is protected from starvation by a counter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction word width.
- MEM_LAT, 1, cycles the memory address is held before data is sampled; legal values ≥1.
- STARVE_MAX, 4, consecutive F grants while D waits before D is forced through; legal values ≥1.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request; held with f_addr until f_gnt.
- f_addr  in  ADDR_W  fetch byte address.
- f_gnt  out  1  one-cycle pulse: F request accepted this cycle.
- f_rvalid  out  1  one-cycle pulse: f_rdata valid.
- f_rdata  out  DATA_W  fetch read data; holds last value.
- d_req  in  1  debug request; held with d_addr until d_gnt.
- d_addr  in  ADDR_W  debug byte address.
- d_gnt  out  1  one-cycle pulse: D request accepted.
- d_rvalid  out  1  one-cycle pulse: d_rdata valid.
- d_rdata  out  DATA_W  debug read data; holds last value.
- m_addr  out  ADDR_W  address to instruction memory (registered).
- m_rdata  in  DATA_W  combinational data from instruction memory.

Behaviour:
Reset:
- All outputs 0, state IDLE, wait counter 0, starvation counter 0, owner = F.
- Reset mid-access abandons the access: no rvalid is produced for it.

FSM states: IDLE, WAIT, RESP.
- IDLE/RESP: if any request is pending, grant one (gnt pulse in the same cycle), latch its address into m_addr and owner, go to WAIT with counter=0. Otherwise go to (or stay in) IDLE.
- WAIT: counter increments each cycle. In the cycle counter==MEM_LAT-1, m_rdata is captured into the owner's rdata register; go to RESP.
- RESP: owner's rvalid=1 for this cycle only. A new grant may occur in this same cycle.

Timing:
- Grant at cycle T, m_addr valid from T+1, rvalid at T+MEM_LAT+1.
- Back-to-back accesses are spaced MEM_LAT+1 cycles apart.

Arbitration:
- F wins when both request, unless starvation counter==STARVE_MAX and d_req=1; then D wins.
- Starvation counter increments on each F grant while d_req=1, saturating at STARVE_MAX.
- Starvation counter clears on a D grant, or in any cycle with d_req=0.
- STARVE_MAX=1 gives strict alternation under contention.

Other rules:
- The non-owner's rdata is never written.
- m_addr holds its value between accesses; it is changed only by a grant.
- Requests are not registered before grant; dropping req before gnt is legal and no grant occurs.
- gnt is never asserted without the corresponding req.

Optional Feature:
Macro IMEM_ARB_ALIGN_CHK_EN.
- When defined: adds outputs f_err and d_err (1 bit each), pulsing together with rvalid.
  - A granted request with addr[1:0]!=0 skips WAIT: next cycle is RESP with rvalid=1, err=1 and rdata forced to 0.
  - m_addr is not updated for that request.
- When undefined: no err ports; misaligned addresses are forwarded unchanged to memory.

Decomposition:
- Shared package (imem_arb_pkg) holds:
  - state encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - owner encoding OWN_F=1'b0, OWN_D=1'b1.
- One natural sub-module: imem_arb_starve (starvation counter plus priority select; inputs f_req, d_req, grant event; outputs sel_d).
- The FSM and data registers remain in the top level.

Test Plan:
1. Single fetch, MEM_LAT=1: f_req with f_addr=0x10 at cycle 2 -> f_gnt at cycle 2, m_addr=0x10 at cycle 3, f_rvalid and f_rdata=mem word at 0x10 at cycle 4.
2. Wait states, MEM_LAT=3: d_req with d_addr=0x20 -> d_rvalid exactly 4 cycles after d_gnt; m_addr stable at 0x20 throughout.
3. Contention, STARVE_MAX=4: f_req and d_req held high -> grants F,F,F,F,D,F,F,F,F,D…; each access spaced MEM_LAT+1 cycles; each rvalid routed to the correct port.
4. Reset mid-WAIT: rst=1 for one cycle, MEM_LAT=3, one cycle after grant -> no rvalid produced; all outputs 0; the next request is served normally.
5. Back-to-back fetch: f_req held high with addresses 0x0, 0x4, 0x8 -> f_gnt on the same cycles as successive f_rvalid; data matches memory words in order.
6. With IMEM_ARB_ALIGN_CHK_EN defined: f_addr=0x6 -> f_rvalid and f_err one cycle after grant; f_rdata=0; m_addr unchanged.
